// File: rtl/lfsr_gen.sv
// Fibonacci LFSR with single-step advance, counted burst engine (busy/done) and XOR-folded output.
// Optional all-zero recovery enabled by defining LFSR_LOCKUP_GUARD_EN.
module lfsr_gen #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = 32'h40001064,
  parameter logic [WIDTH-1:0] SEED  = 32'h00000001,
  parameter int               OUT_W = 8,
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_lfsr,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             step,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lfsr_val,
  output logic [OUT_W-1:0] rnd_out,
  output logic             lockup
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] w_lfsr_nxt;
  logic [WIDTH-1:0] w_shift;
  logic             w_adv;
  logic [OUT_W-1:0] w_rnd;

  assign w_shift = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A load in the same cycle takes precedence over burst acceptance and step.
        if (!ld_lfsr) begin
          if (burst_start) begin
            if (burst_len != '0) begin
              w_cnt_nxt   = burst_len;
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end else if (step) begin
            w_adv = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (ld_lfsr) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_adv     = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef LFSR_LOCKUP_GUARD_EN
  logic w_zero;
  logic r_lockup;

  assign w_zero = (r_lfsr == '0);

  // Zero state reloads SEED on any non-load edge; burst bookkeeping is unaffected.
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (ld_lfsr)    w_lfsr_nxt = ld_val;
    else if (w_zero) w_lfsr_nxt = SEED;
    else if (w_adv)  w_lfsr_nxt = w_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) r_lockup <= 1'b0;
    else     r_lockup <= !ld_lfsr && w_zero;
  end

  assign lockup = r_lockup;
`else
  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (ld_lfsr)    w_lfsr_nxt = ld_val;
    else if (w_adv) w_lfsr_nxt = w_shift;
  end

  assign lockup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_lfsr  <= SEED;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
    end
  end

  always_comb begin
    w_rnd = '0;
    for (int j = 0; j < WIDTH / OUT_W; j++) w_rnd = w_rnd ^ r_lfsr[j*OUT_W +: OUT_W];
  end

  assign busy     = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);
  assign lfsr_val = r_lfsr;
  assign rnd_out  = w_rnd;

endmodule
